// File: rtl/dram_writeback_ctrl_pkg.sv
// Shared types and default sizing for the DRAM write-back controller.
package dram_writeback_ctrl_pkg;

    localparam int unsigned DEF_DRAM_ADDR_WIDTH   = 18;
    localparam int unsigned DEF_OUTPUT_ADDR_WIDTH = 16;
    localparam int unsigned DEF_DATA_WIDTH        = 32;
    localparam int unsigned DEF_BRAM_RD_LATENCY   = 2;
    localparam int unsigned DEF_FIFO_DEPTH        = 4;

    // Transfer sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } wb_state_t;

    // Occupancy counter width for a FIFO of the given depth (0..depth inclusive)
    function automatic int unsigned fifo_cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dram_writeback_ctrl_counter.sv
// Loadable up-counter used for the BRAM read and DRAM write address streams.
module wb_addr_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] ld_val_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] r_q;

    // Load has priority over increment; increment wraps naturally
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_q <= '0;
        end else if (ld_i) begin
            r_q <= ld_val_i;
        end else if (inc_i) begin
            r_q <= r_q + WIDTH'(1);
        end
    end

    assign q_o = r_q;

endmodule

// File: rtl/dram_writeback_ctrl_fifo.sv
// Synchronous skid FIFO absorbing BRAM read data ahead of the DRAM write port.
import dram_writeback_ctrl_pkg::*;

module wb_skid_fifo #(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_FIFO_DEPTH,
    localparam int unsigned PTR_W     = $clog2(DEPTH),
    localparam int unsigned CNT_W     = fifo_cnt_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  empty_o,
    output logic                  full_o
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    // Storage and pointers; storage is cleared so the head reads zero after reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) begin
                r_mem[r_wr_ptr] <= push_data_i;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (pop_i) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign pop_data_o = r_mem[r_rd_ptr];
    assign count_o    = r_count;
    assign empty_o    = (r_count == '0);
    assign full_o     = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/dram_writeback_ctrl.sv
// Drains the output-feature BRAM into a DRAM word range over a valid/ready write stream.
import dram_writeback_ctrl_pkg::*;

module dram_writeback_ctrl #(
    parameter int unsigned DRAM_ADDR_WIDTH   = DEF_DRAM_ADDR_WIDTH,
    parameter int unsigned OUTPUT_ADDR_WIDTH = DEF_OUTPUT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int unsigned BRAM_RD_LATENCY   = DEF_BRAM_RD_LATENCY,
    parameter int unsigned FIFO_DEPTH        = DEF_FIFO_DEPTH
) (
    input  logic                         clk_i,
    input  logic                         general_rst_i,
    input  logic                         start_i,
    input  logic [DRAM_ADDR_WIDTH-1:0]   output_start_addr_dram_i,
    input  logic [DRAM_ADDR_WIDTH-1:0]   output_finish_addr_dram_i,
    input  logic [OUTPUT_ADDR_WIDTH-1:0] out_buf_base_addr_i,
    output logic                         out_buf_rd_en_o,
    output logic [OUTPUT_ADDR_WIDTH-1:0] out_buf_rd_addr_o,
    input  logic [DATA_WIDTH-1:0]        out_buf_rd_data_i,
    output logic                         dram_wr_valid_o,
    input  logic                         dram_wr_ready_i,
    output logic [DRAM_ADDR_WIDTH-1:0]   dram_wr_addr_o,
    output logic [DATA_WIDTH-1:0]        dram_wr_data_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o
);

    localparam int unsigned WCNT_W = DRAM_ADDR_WIDTH + 1;
    localparam int unsigned FCNT_W = fifo_cnt_width(FIFO_DEPTH);
    localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + BRAM_RD_LATENCY + 2) + 1;

    wb_state_t                    r_state;
    logic [DRAM_ADDR_WIDTH-1:0]   r_start;
    logic [DRAM_ADDR_WIDTH-1:0]   r_finish;
    logic [WCNT_W-1:0]            r_rd_left;
    logic                         r_rd_en;
    logic [BRAM_RD_LATENCY-1:0]   r_pipe;
    logic                         r_busy;
    logic                         r_done;
    logic                         r_err;

    logic                         w_start_acc;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_fifo_empty;
    logic                         w_fifo_full;
    logic [FCNT_W-1:0]            w_fifo_count;
    logic [OCC_W-1:0]             w_inflight;
    logic [OCC_W-1:0]             w_occ;
    logic                         w_issue;
    logic                         w_drained;

    assign w_start_acc = (r_state == ST_IDLE) && start_i;
    assign w_push      = r_pipe[BRAM_RD_LATENCY-1];
    assign w_pop       = !w_fifo_empty && dram_wr_ready_i;

    // Credit: FIFO entries after this cycle's pop plus every read not yet pushed
    always_comb begin
        w_inflight = OCC_W'(r_rd_en);
        for (int unsigned i = 0; i < BRAM_RD_LATENCY; i++) begin
            w_inflight = w_inflight + OCC_W'(r_pipe[i]);
        end
        w_occ     = OCC_W'(w_fifo_count) + w_inflight - OCC_W'(w_pop);
        w_issue   = (r_state == ST_READ) && (w_occ < OCC_W'(FIFO_DEPTH));
        w_drained = !r_rd_en && (r_pipe == '0) &&
                    ((w_fifo_count == '0) || ((w_fifo_count == FCNT_W'(1)) && w_pop));
    end

    // Transfer sequencer with registered control outputs and read-valid pipe
    always_ff @(posedge clk_i) begin
        if (general_rst_i) begin
            r_state   <= ST_IDLE;
            r_start   <= '0;
            r_finish  <= '0;
            r_rd_left <= '0;
            r_rd_en   <= 1'b0;
            r_pipe    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            r_done  <= 1'b0;
            r_pipe  <= (r_pipe << 1) | BRAM_RD_LATENCY'(r_rd_en);
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_start  <= output_start_addr_dram_i;
                        r_finish <= output_finish_addr_dram_i;
                        r_busy   <= 1'b1;
                        r_err    <= 1'b0;
                        r_state  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (r_finish < r_start) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_rd_left <= WCNT_W'(r_finish) - WCNT_W'(r_start) + WCNT_W'(1);
                        r_state   <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (w_issue) begin
                        r_rd_en   <= 1'b1;
                        r_rd_left <= r_rd_left - WCNT_W'(1);
                        if (r_rd_left == WCNT_W'(1)) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_drained) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // BRAM read address: points at the word for the read currently on the port
    wb_addr_counter #(.WIDTH(OUTPUT_ADDR_WIDTH)) u_rd_addr (
        .clk_i    (clk_i),
        .rst_i    (general_rst_i),
        .ld_i     (w_start_acc),
        .ld_val_i (out_buf_base_addr_i),
        .inc_i    (r_rd_en),
        .q_o      (out_buf_rd_addr_o)
    );

    // DRAM write address: advances only on an accepted write
    wb_addr_counter #(.WIDTH(DRAM_ADDR_WIDTH)) u_wr_addr (
        .clk_i    (clk_i),
        .rst_i    (general_rst_i),
        .ld_i     (w_start_acc),
        .ld_val_i (output_start_addr_dram_i),
        .inc_i    (w_pop),
        .q_o      (dram_wr_addr_o)
    );

    wb_skid_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (general_rst_i),
        .push_i      (w_push),
        .push_data_i (out_buf_rd_data_i),
        .pop_i       (w_pop),
        .pop_data_o  (dram_wr_data_o),
        .count_o     (w_fifo_count),
        .empty_o     (w_fifo_empty),
        .full_o      (w_fifo_full)
    );

    // Read credit must keep landing data from ever meeting a full FIFO
    a_no_overflow: assert property (@(posedge clk_i) disable iff (general_rst_i)
        !(w_push && w_fifo_full && !w_pop));

    assign out_buf_rd_en_o = r_rd_en;
    assign dram_wr_valid_o = !w_fifo_empty;
    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign err_o           = r_err;

endmodule

// File: tb/tb_dram_writeback_ctrl.sv
// Directed, table-driven bench for dram_writeback_ctrl with a BRAM latency model and write scoreboard.
module tb_dram_writeback_ctrl;

    localparam int unsigned DAW   = 18;
    localparam int unsigned OAW   = 16;
    localparam int unsigned DW    = 32;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 4;

    logic            clk_i = 1'b0;
    logic            general_rst_i = 1'b1;
    logic            start_i = 1'b0;
    logic [DAW-1:0]  output_start_addr_dram_i = '0;
    logic [DAW-1:0]  output_finish_addr_dram_i = '0;
    logic [OAW-1:0]  out_buf_base_addr_i = '0;
    logic            out_buf_rd_en_o;
    logic [OAW-1:0]  out_buf_rd_addr_o;
    logic [DW-1:0]   out_buf_rd_data_i;
    logic            dram_wr_valid_o;
    logic            dram_wr_ready_i = 1'b0;
    logic [DAW-1:0]  dram_wr_addr_o;
    logic [DW-1:0]   dram_wr_data_o;
    logic            busy_o;
    logic            done_o;
    logic            err_o;

    dram_writeback_ctrl #(
        .DRAM_ADDR_WIDTH   (DAW),
        .OUTPUT_ADDR_WIDTH (OAW),
        .DATA_WIDTH        (DW),
        .BRAM_RD_LATENCY   (LAT),
        .FIFO_DEPTH        (DEPTH)
    ) dut (
        .clk_i                     (clk_i),
        .general_rst_i             (general_rst_i),
        .start_i                   (start_i),
        .output_start_addr_dram_i  (output_start_addr_dram_i),
        .output_finish_addr_dram_i (output_finish_addr_dram_i),
        .out_buf_base_addr_i       (out_buf_base_addr_i),
        .out_buf_rd_en_o           (out_buf_rd_en_o),
        .out_buf_rd_addr_o         (out_buf_rd_addr_o),
        .out_buf_rd_data_i         (out_buf_rd_data_i),
        .dram_wr_valid_o           (dram_wr_valid_o),
        .dram_wr_ready_i           (dram_wr_ready_i),
        .dram_wr_addr_o            (dram_wr_addr_o),
        .dram_wr_data_o            (dram_wr_data_o),
        .busy_o                    (busy_o),
        .done_o                    (done_o),
        .err_o                     (err_o)
    );

    always #5 clk_i = ~clk_i;

    // BRAM content: a distinct word per address
    function automatic logic [DW-1:0] bram_val(input logic [OAW-1:0] a);
        return {a ^ 16'h3C5A, a};
    endfunction

    // BRAM model: data appears LAT cycles after the read enable
    logic [DW-1:0] bram_pipe [LAT];
    always @(posedge clk_i) begin
        bram_pipe[0] <= out_buf_rd_en_o ? bram_val(out_buf_rd_addr_o) : 32'hDEAD_BEEF;
        for (int i = 1; i < LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
    end
    assign out_buf_rd_data_i = bram_pipe[LAT-1];

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor state, sampled mid-cycle
    logic [DAW-1:0] wa [$];
    logic [DW-1:0]  wd [$];
    int rd_cnt, first_rd, first_v, done_cnt, stall_viol, busy_viol;
    bit prev_stall;
    logic [DAW-1:0] p_addr;
    logic [DW-1:0]  p_data;

    always @(negedge clk_i) begin
        if (!general_rst_i) begin
            if (out_buf_rd_en_o) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (dram_wr_valid_o && first_v < 0) first_v = cyc;
            if (dram_wr_valid_o && dram_wr_ready_i) begin
                wa.push_back(dram_wr_addr_o);
                wd.push_back(dram_wr_data_o);
            end
            if (prev_stall && (!dram_wr_valid_o || dram_wr_addr_o != p_addr || dram_wr_data_o != p_data))
                stall_viol++;
            prev_stall = dram_wr_valid_o && !dram_wr_ready_i;
            p_addr = dram_wr_addr_o;
            p_data = dram_wr_data_o;
            if (done_o) begin
                done_cnt++;
                if (busy_o) busy_viol++;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        string          name;
        logic [DAW-1:0] s;
        logic [DAW-1:0] f;
        logic [OAW-1:0] b;
        int             mode;   // 0 ready high, 1 ready toggling, 2 ready low for 20 cycles
        bit             poke;   // pulse start_i mid-transfer
        int             exp_n;
        bit             exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic clear_mon();
        wa.delete(); wd.delete();
        rd_cnt = 0; first_rd = -1; first_v = -1;
        done_cnt = 0; stall_viol = 0; busy_viol = 0;
    endtask

    task automatic check_writes(input string nm, input vec_t v, input int n);
        chk({nm, "_nwrites"}, longint'(wa.size()), longint'(n));
        for (int i = 0; i < wa.size() && i < n; i++) begin
            chk($sformatf("%s_addr%0d", nm, i), longint'(wa[i]), longint'(v.s + DAW'(i)));
            chk($sformatf("%s_data%0d", nm, i), longint'(wd[i]), longint'(bram_val(v.b + OAW'(i))));
        end
    endtask

    task automatic run_vec(input vec_t v);
        int stall_rd;
        stall_rd = -1;
        clear_mon();
        output_start_addr_dram_i  = v.s;
        output_finish_addr_dram_i = v.f;
        out_buf_base_addr_i       = v.b;
        dram_wr_ready_i           = (v.mode != 2);
        start_i                   = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        chk({v.name, "_busy_after_start"}, longint'(busy_o), 1);
        for (int c = 0; c < 600; c++) begin
            case (v.mode)
                1:       dram_wr_ready_i = ((c % 2) == 0);
                2:       dram_wr_ready_i = (c >= 20);
                default: dram_wr_ready_i = 1'b1;
            endcase
            if (v.poke && c == 1) begin
                start_i = 1'b1;
                output_start_addr_dram_i  = 18'h00010;
                output_finish_addr_dram_i = 18'h0001F;
                out_buf_base_addr_i       = 16'h0000;
            end else begin
                start_i = 1'b0;
            end
            if (v.mode == 2 && c == 19) stall_rd = rd_cnt;
            @(posedge clk_i); #1;
            if (done_cnt > 0) break;
        end
        start_i = 1'b0;
        dram_wr_ready_i = 1'b1;
        repeat (6) @(posedge clk_i);
        #1;
        check_writes(v.name, v, v.exp_n);
        chk({v.name, "_done_pulses"}, longint'(done_cnt), 1);
        chk({v.name, "_busy_with_done"}, longint'(busy_viol), 0);
        chk({v.name, "_err"}, longint'(err_o), longint'(v.exp_err));
        chk({v.name, "_busy_idle"}, longint'(busy_o), 0);
        chk({v.name, "_stall_stable"}, longint'(stall_viol), 0);
        chk({v.name, "_reads"}, longint'(rd_cnt), longint'(v.exp_n));
        if (v.exp_n > 0) chk({v.name, "_latency"}, longint'(first_v - first_rd), longint'(LAT + 1));
        if (v.mode == 2) chk({v.name, "_stalled_reads"}, longint'(stall_rd), longint'(DEPTH));
    endtask

    initial begin
        vecs[0] = '{"ready_hi",   18'h00100, 18'h0010F, 16'h0000, 0, 1'b0, 16, 1'b0};
        vecs[1] = '{"ready_tog",  18'h00100, 18'h0010F, 16'h0000, 1, 1'b0, 16, 1'b0};
        vecs[2] = '{"ready_stall",18'h00100, 18'h0010F, 16'h0000, 2, 1'b0, 16, 1'b0};
        vecs[3] = '{"bad_range",  18'h00020, 18'h0001F, 16'h0000, 0, 1'b0, 0,  1'b1};
        vecs[4] = '{"rd_wrap",    18'h00040, 18'h00047, 16'hFFFC, 0, 1'b0, 8,  1'b0};
        vecs[5] = '{"top_single", 18'h3FFFF, 18'h3FFFF, 16'hFFFF, 0, 1'b1, 1,  1'b0};

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ctrl", longint'({out_buf_rd_en_o, dram_wr_valid_o, busy_o, done_o, err_o}), 0);
        chk("rst_rd_addr", longint'(out_buf_rd_addr_o), 0);
        chk("rst_wr_addr", longint'(dram_wr_addr_o), 0);
        chk("rst_wr_data", longint'(dram_wr_data_o), 0);
        general_rst_i = 1'b0;
        @(posedge clk_i); #1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset at word 5 of 16 aborts the transfer
        clear_mon();
        output_start_addr_dram_i  = vecs[0].s;
        output_finish_addr_dram_i = vecs[0].f;
        out_buf_base_addr_i       = vecs[0].b;
        dram_wr_ready_i           = 1'b1;
        start_i                   = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk_i); #1;
            if (wa.size() >= 5) break;
        end
        general_rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("midrst_ctrl", longint'({out_buf_rd_en_o, dram_wr_valid_o, busy_o, done_o, err_o}), 0);
        chk("midrst_rd_addr", longint'(out_buf_rd_addr_o), 0);
        chk("midrst_wr_addr", longint'(dram_wr_addr_o), 0);
        chk("midrst_wr_data", longint'(dram_wr_data_o), 0);
        general_rst_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        check_writes("midrst", vecs[0], 5);
        chk("midrst_no_done", longint'(done_cnt), 0);

        // Clean transfer after the abort
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
